uart_rx: RTL and testbench

- Receive half of the UART pair: recovers serial frames from line `rxd` and presents the data word in parallel.
- Frame format matches the transmitter: 1 start bit (0), `data_bits` data bits LSB first, 1 stop bit (1), no parity.
- Uses the same 3-bit `br` baud-select encoding as the transmitter.
- Samples at 16x oversampling with 3-sample majority vote, so the transmitter's `txd` loops back directly into `rxd` in system benches.

---
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Receive half of the UART pair. Recovers 8N1-style frames (1 start bit,
// data_bits data bits LSB first, 1 stop bit, no parity) from the serial
// line using 16x oversampling and a 3-sample majority vote per bit.
//
// Parameters
//   data_bits                  width of the received data word
//   received_bit_counter_bits  width of the data-bit index (2^n > data_bits)
//   br                         baud select; tick interval N = os_div >> br
//   os_div                     sysclk cycles per 16x tick at br = 3'b000
//
// Ports
//   sysclk     system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   rxd        asynchronous serial line, idles high
//   DBUS       last correctly framed data word
//   rxd_doneH  one-cycle pulse: new word valid on DBUS
//   rxd_errH   one-cycle pulse: framing error (stop bit sampled 0)
//   rxd_busyH  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int         data_bits                 = 8,
    parameter int         received_bit_counter_bits = 4,
    parameter logic [2:0] br                        = 3'b000,
    parameter int         os_div                    = 128
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [data_bits-1:0] DBUS,
    output logic                 rxd_doneH,
    output logic                 rxd_errH,
    output logic                 rxd_busyH
);

    // Oversample tick interval; clamp so an aggressive br never yields zero.
    localparam int N_RAW = os_div >> br;
    localparam int N     = (N_RAW < 1) ? 1 : N_RAW;
    localparam int TW    = (N > 1) ? $clog2(N) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(N - 1);
    localparam logic [received_bit_counter_bits-1:0] LAST_BIT =
        received_bit_counter_bits'(data_bits - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                                state_reg;
    logic                                  rx_meta_reg;
    logic                                  rxs_reg;
    logic                                  rxs_prev_reg;
    logic [TW-1:0]                         tick_cnt_reg;
    logic [3:0]                            sample_cnt_reg;
    logic [received_bit_counter_bits-1:0]  bit_idx_reg;
    logic [data_bits-1:0]                  shift_reg;
    logic [data_bits-1:0]                  shift_next;
    logic [1:0]                            early_votes_reg;

    logic tick;
    logic start_edge;
    logic decide;
    logic vote;

    assign tick       = (tick_cnt_reg == TICK_LAST);
    assign start_edge = (state_reg == IDLE) && rxs_prev_reg && !rxs_reg;

    // "Tick k" is the tick that advances the sample counter to k. The votes
    // are taken at ticks 7 and 8 and the bit is decided at tick 9, so the
    // decision lands close to the centre of the bit period.
    assign decide = tick && (sample_cnt_reg == 4'd8);
    assign vote   = (early_votes_reg[0] & early_votes_reg[1]) |
                    (early_votes_reg[0] & rxs_reg) |
                    (early_votes_reg[1] & rxs_reg);

    // New bits enter from the MSB side so the first received bit ends at bit 0.
    always_comb begin
        shift_next                = shift_reg >> 1;
        shift_next[data_bits-1]   = vote;
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_reg       <= IDLE;
            rx_meta_reg     <= 1'b1;
            rxs_reg         <= 1'b1;
            rxs_prev_reg    <= 1'b1;
            tick_cnt_reg    <= '0;
            sample_cnt_reg  <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            early_votes_reg <= 2'b11;
            DBUS            <= '0;
            rxd_doneH       <= 1'b0;
            rxd_errH        <= 1'b0;
            rxd_busyH       <= 1'b0;
        end else begin
            // Two-flop synchroniser, plus one more flop for edge detection.
            rx_meta_reg  <= rxd;
            rxs_reg      <= rx_meta_reg;
            rxs_prev_reg <= rxs_reg;

            rxd_doneH <= 1'b0;
            rxd_errH  <= 1'b0;

            // Clearing on the start edge phase-aligns the whole frame to it.
            if (start_edge) begin
                tick_cnt_reg   <= '0;
                sample_cnt_reg <= '0;
            end else if (tick) begin
                tick_cnt_reg   <= '0;
                sample_cnt_reg <= sample_cnt_reg + 4'd1;
            end else begin
                tick_cnt_reg   <= tick_cnt_reg + TW'(1);
            end

            if (tick && (sample_cnt_reg == 4'd6)) begin
                early_votes_reg[0] <= rxs_reg;
            end
            if (tick && (sample_cnt_reg == 4'd7)) begin
                early_votes_reg[1] <= rxs_reg;
            end

            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        state_reg <= START;
                        rxd_busyH <= 1'b1;
                    end
                end
                START: begin
                    if (decide) begin
                        if (!vote) begin
                            state_reg   <= DATA;
                            bit_idx_reg <= '0;
                        end else begin
                            // Start bit did not hold low: treat as a glitch.
                            state_reg <= IDLE;
                            rxd_busyH <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_reg <= shift_next;
                        if (bit_idx_reg == LAST_BIT) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Returning to IDLE mid-stop-bit lets a start edge that
                    // follows immediately be caught without loss.
                    if (decide) begin
                        if (vote) begin
                            DBUS      <= shift_reg;
                            rxd_doneH <= 1'b1;
                            state_reg <= IDLE;
                            rxd_busyH <= 1'b0;
                        end else begin
                            rxd_errH  <= 1'b1;
                            state_reg <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // A line held low yields one error only; wait for idle.
                    if (rxs_reg) begin
                        state_reg <= IDLE;
                        rxd_busyH <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rxd_busyH <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Two receivers share the serial line:
// dut_a uses os_div=4, br=000 and dut_b uses os_div=16, br=010, both giving
// N=4 (64 cycles per bit), so they must decode identically. Expected words,
// error counts and DBUS contents come from a frame-level model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CYCLES = 64;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic       rxd    = 1'b1;
    logic [7:0] dbus_a, dbus_b;
    logic       done_a, done_b, err_a, err_b, busy_a, busy_b;

    always #5 sysclk = ~sysclk;

    uart_rx #(
        .data_bits(8), .received_bit_counter_bits(4), .br(3'b000), .os_div(4)
    ) dut_a (
        .sysclk(sysclk), .rst(rst), .rxd(rxd), .DBUS(dbus_a),
        .rxd_doneH(done_a), .rxd_errH(err_a), .rxd_busyH(busy_a)
    );

    uart_rx #(
        .data_bits(8), .received_bit_counter_bits(4), .br(3'b010), .os_div(16)
    ) dut_b (
        .sysclk(sysclk), .rst(rst), .rxd(rxd), .DBUS(dbus_b),
        .rxd_doneH(done_b), .rxd_errH(err_b), .rxd_busyH(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: words that should arrive, error count, DBUS content.
    logic [7:0] exp_q[$];
    int         exp_err  = 0;
    logic [7:0] exp_dbus = 8'h00;

    // Observations gathered by the monitor.
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int         err_cnt_a = 0;
    int         err_cnt_b = 0;
    logic       prev_done_a = 1'b0, prev_done_b = 1'b0;
    logic       prev_err_a  = 1'b0, prev_err_b  = 1'b0;

    always begin
        @(posedge sysclk);
        #1;
        if (done_a) got_a.push_back(dbus_a);
        if (done_b) got_b.push_back(dbus_b);
        if (err_a) err_cnt_a++;
        if (err_b) err_cnt_b++;
        // Pulses are single-cycle and mutually exclusive.
        if (done_a || err_a)
            check_value("pulse_shape_a",
                        {29'd0, done_a & err_a, done_a & prev_done_a, err_a & prev_err_a}, 32'd0);
        if (done_b || err_b)
            check_value("pulse_shape_b",
                        {29'd0, done_b & err_b, done_b & prev_done_b, err_b & prev_err_b}, 32'd0);
        prev_done_a = done_a;
        prev_done_b = done_b;
        prev_err_a  = err_a;
        prev_err_b  = err_b;
    end

    task automatic idle(input int cycles);
        rxd = 1'b1;
        repeat (cycles) @(negedge sysclk);
    endtask

    // Drive nbits of a frame (start, data LSB first, stop). An optional
    // single-cycle spike inverts the line inside bit spike_bit.
    task automatic send_bits(input logic [7:0] d, input logic stop, input int period,
                             input int nbits, input int spike_bit, input int spike_off);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < period; c++) begin
                rxd = (i == spike_bit && c == spike_off) ? ~bits[i] : bits[i];
                @(negedge sysclk);
            end
        end
    endtask

    task automatic send_good(input logic [7:0] d, input int period);
        send_bits(d, 1'b1, period, 10, -1, 0);
        exp_q.push_back(d);
        exp_dbus = d;
    endtask

    task automatic finish_scenario(input string tag);
        idle(150);
        check_value({tag, "_count_a"}, got_a.size(), exp_q.size());
        check_value({tag, "_count_b"}, got_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_a.size()) check_value({tag, "_data_a"}, got_a[i], exp_q[i]);
            if (i < got_b.size()) check_value({tag, "_data_b"}, got_b[i], exp_q[i]);
            $display("%s frame %0d: expected 0x%02h", tag, i, exp_q[i]);
        end
        check_value({tag, "_errs_a"}, err_cnt_a, exp_err);
        check_value({tag, "_errs_b"}, err_cnt_b, exp_err);
        check_value({tag, "_dbus_a"}, dbus_a, exp_dbus);
        check_value({tag, "_dbus_b"}, dbus_b, exp_dbus);
        check_value({tag, "_busy"}, {busy_b, busy_a}, 32'd0);
        got_a.delete();
        got_b.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        int         period, gap;

        repeat (5) @(negedge sysclk);
        check_value("reset_outputs_a", {dbus_a, done_a, err_a, busy_a}, 32'd0);
        check_value("reset_outputs_b", {dbus_b, done_b, err_b, busy_b}, 32'd0);
        rst = 1'b0;
        idle(20);

        // Good frame.
        send_good(8'hA5, BIT_CYCLES);
        finish_scenario("good");

        // Back-to-back frames with no idle gap.
        send_good(8'h00, BIT_CYCLES);
        send_good(8'hFF, BIT_CYCLES);
        send_good(8'h3C, BIT_CYCLES);
        finish_scenario("b2b");

        // Short low glitch must not start a frame.
        rxd = 1'b0;
        repeat (20) @(negedge sysclk);
        finish_scenario("glitch");

        // Framing error followed by a held-low line, then a good frame.
        send_bits(8'h5A, 1'b0, BIT_CYCLES, 10, -1, 0);
        rxd = 1'b0;
        repeat (200) @(negedge sysclk);
        exp_err++;
        finish_scenario("framing");
        send_good(8'h81, BIT_CYCLES);
        finish_scenario("after_err");

        // One-cycle spike at the centre of data bit 3 (frame bit 4).
        send_bits(8'hF0, 1'b1, BIT_CYCLES, 10, 4, BIT_CYCLES / 2);
        exp_q.push_back(8'hF0);
        exp_dbus = 8'hF0;
        finish_scenario("spike");

        // Reset in the middle of a frame aborts it and clears DBUS.
        send_bits(8'h77, 1'b1, BIT_CYCLES, 4, -1, 0);
        rxd = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        exp_dbus = 8'h00;
        check_value("midreset_a", {dbus_a, done_a, err_a, busy_a}, 32'd0);
        check_value("midreset_b", {dbus_b, done_b, err_b, busy_b}, 32'd0);
        finish_scenario("midreset");
        send_good(8'h12, BIT_CYCLES);
        finish_scenario("after_reset");

        // Random words at bit periods within +/-3% and random gaps.
        for (int f = 0; f < 12; f++) begin
            d      = 8'($urandom);
            period = $urandom_range(66, 62);
            gap    = $urandom_range(30, 0);
            send_good(d, period);
            idle(gap);
        end
        finish_scenario("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
